// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused LSB-first,
// one chunk per clock, with carry/overflow/zero flags and start/busy/done handshake.
module seq_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [CHUNK:0]   sum;
   logic             accept, last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (idx == IW'(N - 1)) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands shift right so the active chunk always sits in the low bits;
   // on the final chunk the low slice holds the operand MSBs used for V.
   always_comb begin
      sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
      acc_next = acc;
      acc_next[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         S     <= '0;
         Cout  <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b0;
         done  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         acc   <= '0;
         idx   <= '0;
      end else begin
         done <= last;
         if (accept) begin
            a_sh  <= A;
            b_sh  <= SUB ? ~B : B;
            carry <= SUB ? ~Cin : Cin;
            acc   <= '0;
            idx   <= '0;
         end else if (state == RUN) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            carry <= sum[CHUNK];
            acc   <= acc_next;
            idx   <= idx + IW'(1);
            if (last) begin
               S    <= acc_next;
               Cout <= sum[CHUNK];
               V    <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) && (sum[CHUNK-1] != a_sh[CHUNK-1]);
               Z    <= (acc_next == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub (WIDTH=32, CHUNK=4): expected results are
// queued at issue time from a full-width reference model and popped on done.
module tb_seq_addsub;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        SUB = 1'b0;
   logic        Cin = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [31:0] S;
   logic        Cout, V, Z, busy, done;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   seq_addsub #(.WIDTH(32), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .SUB(SUB), .A(A), .B(B), .Cin(Cin),
      .S(S), .Cout(Cout), .V(V), .Z(Z), .busy(busy), .done(done)
   );

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      logic [31:0] bp;
      logic        c0;
      logic [32:0] full;
      res_t        r;
      bp   = sub ? ~b : b;
      c0   = sub ? ~cin : cin;
      full = {1'b0, a} + {1'b0, bp} + {32'd0, c0};
      r.s  = full[31:0];
      r.c  = full[32];
      r.v  = (a[31] == bp[31]) && (full[31] != a[31]);
      r.z  = (full[31:0] == 32'd0);
      return r;
   endfunction

   // Drives start for one edge; returns #1 after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input bit keep);
      A = a; B = b; SUB = sub; Cin = cin; start = 1'b1;
      if (keep) exp_q.push_back(model(a, b, sub, cin));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop_exp(output res_t e);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; A = 32'h1234_5678; B = 32'h1; 
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: done=%b busy=%b expected 0 0", done, busy);
         end
      end
      rst = 1'b0; start = 1'b0;
      checks++;
      if ({S, Cout, V, Z} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {S, Cout, V, Z});
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_add_wrap;
      int lat, bc;
      res_t e;
      issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
      wait_done(lat, bc);
      checks++;
      if (lat != 8 || bc != 8) begin
         errors++;
         $display("FAIL add_wrap_latency: lat=%0d busy_cycles=%0d expected 8 8", lat, bc);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL add_wrap_busy_in_done: got %b expected 0", busy);
      end
      pop_exp(e);
      checks++;
      if ({S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL add_wrap_result: got %h expected %h", {S, Cout, V, Z}, e);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || {S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL add_wrap_pulse_hold: done=%b out=%h expected 0 %h", done, {S, Cout, V, Z}, e);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] ta [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
      logic        ts [2] = '{1'b0, 1'b1};
      int lat, bc;
      res_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], 32'h1, ts[i], 1'b0, 1'b1);
         wait_done(lat, bc);
         pop_exp(e);
         checks++;
         if (lat != 8 || {S, Cout, V, Z} !== e) begin
            errors++;
            $display("FAIL overflow_%0d: lat=%0d out=%h expected 8 %h", i, lat, {S, Cout, V, Z}, e);
         end
      end
   endtask

   task automatic test_sub_borrow;
      logic [31:0] ta [2] = '{32'd5, 32'd10};
      logic [31:0] tb [2] = '{32'd7, 32'd3};
      logic        tc [2] = '{1'b0, 1'b1};
      int lat, bc;
      res_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i], 1'b1, tc[i], 1'b1);
         wait_done(lat, bc);
         pop_exp(e);
         checks++;
         if (lat != 8 || {S, Cout, V, Z} !== e) begin
            errors++;
            $display("FAIL sub_borrow_%0d: lat=%0d out=%h expected 8 %h", i, lat, {S, Cout, V, Z}, e);
         end
      end
   endtask

   task automatic test_ignore_start;
      res_t e;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         start = (k == 3 || k == 5);
         A = $urandom; B = $urandom; SUB = 1'($urandom); Cin = 1'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      pop_exp(e);
      checks++;
      if (done !== 1'b1 || {S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL ignore_start_result: done=%b out=%h expected 1 %h", done, {S, Cout, V, Z}, e);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_not_queued: done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      res_t e;
      issue(32'd100, 32'd23, 1'b0, 1'b0, 1'b1);
      wait_done(lat, bc);
      pop_exp(e);
      checks++;
      if (done !== 1'b1 || {S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL b2b_first: done=%b out=%h expected 1 %h", done, {S, Cout, V, Z}, e);
      end
      issue(32'd9, 32'd6, 1'b0, 1'b0, 1'b1);
      wait_done(lat, bc);
      pop_exp(e);
      checks++;
      if (lat != 8 || {S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d out=%h expected 8 %h", lat, {S, Cout, V, Z}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int lat, bc, dones;
      res_t e;
      issue(32'd2, 32'd4, 1'b0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || S !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_abort: busy=%b done=%b S=%h expected 0 0 0", busy, done, S);
      end
      dones = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
      end
      issue(32'd2, 32'd4, 1'b0, 1'b0, 1'b1);
      wait_done(lat, bc);
      pop_exp(e);
      checks++;
      if (lat != 8 || {S, Cout, V, Z} !== e) begin
         errors++;
         $display("FAIL reset_mid_restart: lat=%0d out=%h expected 8 %h", lat, {S, Cout, V, Z}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int lat, bc;
      res_t e;
      issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) begin
         wait_done(lat, bc);
         pop_exp(e);
         checks++;
         if (lat != 8 || {S, Cout, V, Z} !== e) begin
            errors++;
            $display("FAIL random_%0d: lat=%0d out=%h expected 8 %h", i, lat, {S, Cout, V, Z}, e);
         end
         if (i < 5) issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_overflow();
      test_sub_borrow();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
